alu_rs: RTL and testbench
=========================

# alu_rs

Reservation station feeding the integer ALU in the out-of-order core. It accepts decoded integer, branch and jump ops from the dispatcher and holds them until both source operands are valid. Operands are captured from the two common data buses (ALU CDB, LSB CDB). It issues at most one ready op per cycle as a registered operation bundle to the combinational ALU, and returns the ROB tag so the result can be broadcast.

## Interface
- RS_SIZE, 16, number of entries (power of two)
- TAG_W, 4, ROB tag width
- OPENUM_W, 6, opcode-enum width (shared OPENUM_TYPE)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; low freezes all state
- flush  in  1  misprediction rollback; clears all entries
- in_valid  in  1  dispatch strobe
- in_openum  in  OPENUM_W  op; OPENUM_NOP is never dispatched
- in_v1, in_v2  in  32  operand values, meaningful when matching q-valid is 0
- in_q1_valid, in_q2_valid  in  1  operand still pending
- in_q1, in_q2  in  TAG_W  producer ROB tags
- in_imm  in  32  immediate; in_pc  in  32  instruction PC
- in_rob_tag  in  TAG_W  destination ROB tag
- full  out  1  no free entry (combinational from registered busy bits)
- alu_cdb_valid, lsb_cdb_valid  in  1  broadcast strobes
- alu_cdb_tag, lsb_cdb_tag  in  TAG_W; alu_cdb_value, lsb_cdb_value  in  32
- out_openum  out  OPENUM_W  to ALU; OPENUM_NOP when idle
- out_v1, out_v2, out_imm, out_pc  out  32  to ALU
- out_rob_tag  out  TAG_W  tag accompanying the ALU result

## Operation
- Per entry: busy, openum, v1, v2, q1_valid, q1, q2_valid, q2, imm, pc, rob_tag.
- Dispatch: if in_valid && !full, write the lowest-index non-busy entry. If in_valid && full, the op is dropped; the dispatcher must never do this.
- Dispatch bypass: if in_qX_valid and a CDB broadcasts the matching tag in the same cycle, store that value with qX_valid=0.
- Wakeup: every busy entry whose pending qX matches a valid CDB tag captures the value and clears qX_valid. Both CDBs may wake different operands of one entry in the same cycle. If both CDBs carry the same tag (illegal), the ALU CDB wins.
- Ready = busy && !q1_valid && !q2_valid, evaluated on registered state.
- Select: the lowest-index ready entry is issued. Its bundle is registered onto out_*, and busy is cleared at the same edge. With no ready entry, out_openum=NOP and the other out_* are 0.
- A slot freed by issue becomes dispatchable the next cycle, not the same cycle.
- flush: all busy bits cleared and out_openum=NOP at the next edge. It has priority over dispatch, wakeup and issue.
- rdy low: no register changes, including outputs. flush and in_valid are ignored.

## Timing
- Reset (rst_n low, async): all busy=0, out_openum=NOP, out_v1/v2/imm/pc=0, out_rob_tag=0, full=0.
- An entry dispatched with both operands valid at edge N is visible on out_* after edge N+1 (1 cycle in the RS).
- An operand woken at edge N makes the entry eligible for issue at edge N+1.
- out_* are valid for exactly one cycle per issued op. The ALU is combinational, so its result reaches the CDB in the same cycle.
- full changes only after clock edges. Dispatch and issue in the same cycle leave the count unchanged.

## Structure
- Shared constants package / constant.v: OPENUM_* encodings (including OPENUM_NOP), DATA_TYPE, ADDR_TYPE, ROB tag width, RS_SIZE.
- One sub-module, rs_prio_enc: parameterised lowest-index priority encoder with found flag. It is instantiated twice, for free-slot select and ready select.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Reset mid-operation:
  - Stimulus: fill 3 entries, assert rst_n=0 asynchronously.
  - Required response: out_openum=NOP and full=0 immediately; no issue after release.
- Ready dispatch:
  - Stimulus: ADDI, v1=5, imm=7, q-valids 0, rob_tag=3 at edge 0.
  - Required response: edge 1 shows out_openum=ADDI, out_v1=5, out_imm=7, out_rob_tag=3; edge 2 shows NOP.
- Wakeup and dual CDB:
  - Stimulus: ADD with q1=2, q2=5 pending, then alu_cdb(tag 2, value 0x10) and lsb_cdb(tag 5, value 0x20) in the same cycle.
  - Required response: issued next cycle with out_v1=0x10, out_v2=0x20.
- Dispatch bypass:
  - Stimulus: dispatch SUB with q1=4 while alu_cdb broadcasts tag 4, value 9.
  - Required response: issues next edge with out_v1=9.
- Full and priority:
  - Stimulus: dispatch 16 blocked ops, then wake entries 7 and 2 together.
  - Required response: full=1; entry 2 issues first, entry 7 the next cycle; full drops after the first issue.
- flush and rdy:
  - Stimulus: assert flush with 5 busy entries; separately, hold rdy=0 for 3 cycles while an entry is ready.
  - Required response: flush leaves out_openum=NOP, full=0 and no later issue. For rdy=0, out_* hold their values and the issue occurs only after rdy returns to 1.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared constants for the integer reservation station: op encodings,
// datapath types, ROB tag width and station depth.
package alu_rs_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int TAG_W    = 4;
  localparam int RS_SIZE  = 16;
  localparam int OPENUM_W = 6;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [OPENUM_W-1:0] {
    OPENUM_NOP = 6'd0,
    OPENUM_LUI, OPENUM_AUIPC, OPENUM_JAL, OPENUM_JALR,
    OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU,
    OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI, OPENUM_ORI, OPENUM_ANDI,
    OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI,
    OPENUM_ADD, OPENUM_SUB, OPENUM_SLL, OPENUM_SLT, OPENUM_SLTU,
    OPENUM_XOR, OPENUM_SRL, OPENUM_SRA, OPENUM_OR, OPENUM_AND
  } openum_t;

endpackage

// File: rtl/alu_rs_prio_enc.sv
// Lowest-index priority encoder with a found flag; used for both the
// free-slot and the ready-entry select.
module rs_prio_enc #(
  parameter int N     = 16,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Integer/branch reservation station: holds dispatched ops until both
// operands arrive from the CDBs, then issues one ready op per cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE  = alu_rs_pkg::RS_SIZE,
  parameter int TAG_W    = alu_rs_pkg::TAG_W,
  parameter int OPENUM_W = alu_rs_pkg::OPENUM_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [OPENUM_W-1:0] in_openum,
  input  logic [31:0]         in_v1,
  input  logic [31:0]         in_v2,
  input  logic                in_q1_valid,
  input  logic                in_q2_valid,
  input  logic [TAG_W-1:0]    in_q1,
  input  logic [TAG_W-1:0]    in_q2,
  input  logic [31:0]         in_imm,
  input  logic [31:0]         in_pc,
  input  logic [TAG_W-1:0]    in_rob_tag,
  output logic                full,
  input  logic                alu_cdb_valid,
  input  logic [TAG_W-1:0]    alu_cdb_tag,
  input  logic [31:0]         alu_cdb_value,
  input  logic                lsb_cdb_valid,
  input  logic [TAG_W-1:0]    lsb_cdb_tag,
  input  logic [31:0]         lsb_cdb_value,
  output logic [OPENUM_W-1:0] out_openum,
  output logic [31:0]         out_v1,
  output logic [31:0]         out_v2,
  output logic [31:0]         out_imm,
  output logic [31:0]         out_pc,
  output logic [TAG_W-1:0]    out_rob_tag
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam logic [OPENUM_W-1:0] NOP = OPENUM_W'(OPENUM_NOP);

  logic [RS_SIZE-1:0]  busy_reg, busy_next;
  logic [OPENUM_W-1:0] openum_reg   [RS_SIZE];
  logic [31:0]         v1_reg       [RS_SIZE];
  logic [31:0]         v2_reg       [RS_SIZE];
  logic                q1_valid_reg [RS_SIZE];
  logic                q2_valid_reg [RS_SIZE];
  logic [TAG_W-1:0]    q1_reg       [RS_SIZE];
  logic [TAG_W-1:0]    q2_reg       [RS_SIZE];
  logic [31:0]         imm_reg      [RS_SIZE];
  logic [31:0]         pc_reg       [RS_SIZE];
  logic [TAG_W-1:0]    rob_tag_reg  [RS_SIZE];

  logic [RS_SIZE-1:0] ready, w1_alu, w1_lsb, w2_alu, w2_lsb;
  logic [IDX_W-1:0]   free_idx, ready_idx;
  logic               free_found, ready_found, dispatch_en, issue_en;

  logic [OPENUM_W-1:0] out_openum_reg;
  logic [31:0]         out_v1_reg, out_v2_reg, out_imm_reg, out_pc_reg;
  logic [TAG_W-1:0]    out_rob_tag_reg;

  genvar gi;
  generate
    for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
      assign ready[gi]  = busy_reg[gi] && !q1_valid_reg[gi] && !q2_valid_reg[gi];
      assign w1_alu[gi] = busy_reg[gi] && q1_valid_reg[gi] && alu_cdb_valid && (q1_reg[gi] == alu_cdb_tag);
      assign w1_lsb[gi] = busy_reg[gi] && q1_valid_reg[gi] && lsb_cdb_valid && (q1_reg[gi] == lsb_cdb_tag);
      assign w2_alu[gi] = busy_reg[gi] && q2_valid_reg[gi] && alu_cdb_valid && (q2_reg[gi] == alu_cdb_tag);
      assign w2_lsb[gi] = busy_reg[gi] && q2_valid_reg[gi] && lsb_cdb_valid && (q2_reg[gi] == lsb_cdb_tag);
    end
  endgenerate

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_enc (
    .req(~busy_reg), .idx(free_idx), .found(free_found)
  );
  rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_ready_enc (
    .req(ready), .idx(ready_idx), .found(ready_found)
  );

  assign full        = ~free_found;
  assign dispatch_en = in_valid && free_found;
  assign issue_en    = ready_found;

  // Dispatch bypass: a pending operand may be satisfied by a same-cycle broadcast.
  logic        byp1_alu, byp1_lsb, byp2_alu, byp2_lsb;
  logic [31:0] new_v1, new_v2;
  assign byp1_alu = in_q1_valid && alu_cdb_valid && (in_q1 == alu_cdb_tag);
  assign byp1_lsb = in_q1_valid && lsb_cdb_valid && (in_q1 == lsb_cdb_tag);
  assign byp2_alu = in_q2_valid && alu_cdb_valid && (in_q2 == alu_cdb_tag);
  assign byp2_lsb = in_q2_valid && lsb_cdb_valid && (in_q2 == lsb_cdb_tag);
  assign new_v1   = byp1_alu ? alu_cdb_value : (byp1_lsb ? lsb_cdb_value : in_v1);
  assign new_v2   = byp2_alu ? alu_cdb_value : (byp2_lsb ? lsb_cdb_value : in_v2);

  always_comb begin
    busy_next = busy_reg;
    if (issue_en)    busy_next[ready_idx] = 1'b0;
    if (dispatch_en) busy_next[free_idx]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     busy_reg <= '0;
    else if (rdy)   busy_reg <= flush ? '0 : busy_next;
  end

  // Entry payload needs no reset: busy gates every use of it.
  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (dispatch_en && (free_idx == IDX_W'(i))) begin
          openum_reg[i]   <= in_openum;
          v1_reg[i]       <= new_v1;
          v2_reg[i]       <= new_v2;
          q1_valid_reg[i] <= in_q1_valid && !byp1_alu && !byp1_lsb;
          q2_valid_reg[i] <= in_q2_valid && !byp2_alu && !byp2_lsb;
          q1_reg[i]       <= in_q1;
          q2_reg[i]       <= in_q2;
          imm_reg[i]      <= in_imm;
          pc_reg[i]       <= in_pc;
          rob_tag_reg[i]  <= in_rob_tag;
        end else begin
          if (w1_alu[i]) begin
            v1_reg[i]       <= alu_cdb_value;
            q1_valid_reg[i] <= 1'b0;
          end else if (w1_lsb[i]) begin
            v1_reg[i]       <= lsb_cdb_value;
            q1_valid_reg[i] <= 1'b0;
          end
          if (w2_alu[i]) begin
            v2_reg[i]       <= alu_cdb_value;
            q2_valid_reg[i] <= 1'b0;
          end else if (w2_lsb[i]) begin
            v2_reg[i]       <= lsb_cdb_value;
            q2_valid_reg[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_openum_reg  <= NOP;
      out_v1_reg      <= '0;
      out_v2_reg      <= '0;
      out_imm_reg     <= '0;
      out_pc_reg      <= '0;
      out_rob_tag_reg <= '0;
    end else if (rdy) begin
      if (!flush && issue_en) begin
        out_openum_reg  <= openum_reg[ready_idx];
        out_v1_reg      <= v1_reg[ready_idx];
        out_v2_reg      <= v2_reg[ready_idx];
        out_imm_reg     <= imm_reg[ready_idx];
        out_pc_reg      <= pc_reg[ready_idx];
        out_rob_tag_reg <= rob_tag_reg[ready_idx];
      end else begin
        out_openum_reg  <= NOP;
        out_v1_reg      <= '0;
        out_v2_reg      <= '0;
        out_imm_reg     <= '0;
        out_pc_reg      <= '0;
        out_rob_tag_reg <= '0;
      end
    end
  end

  assign out_openum  = out_openum_reg;
  assign out_v1      = out_v1_reg;
  assign out_v2      = out_v2_reg;
  assign out_imm     = out_imm_reg;
  assign out_pc      = out_pc_reg;
  assign out_rob_tag = out_rob_tag_reg;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: vector table for single-op dispatch/bypass,
// plus hand sequences for wakeup, full/priority, flush, rdy and reset.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, rdy, flush, in_valid;
  logic [5:0]  in_openum;
  logic [31:0] in_v1, in_v2, in_imm, in_pc;
  logic        in_q1_valid, in_q2_valid;
  logic [3:0]  in_q1, in_q2, in_rob_tag;
  logic        full;
  logic        alu_cdb_valid, lsb_cdb_valid;
  logic [3:0]  alu_cdb_tag, lsb_cdb_tag;
  logic [31:0] alu_cdb_value, lsb_cdb_value;
  logic [5:0]  out_openum;
  logic [31:0] out_v1, out_v2, out_imm, out_pc;
  logic [3:0]  out_rob_tag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_rs dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush), .in_valid(in_valid),
    .in_openum(in_openum), .in_v1(in_v1), .in_v2(in_v2),
    .in_q1_valid(in_q1_valid), .in_q2_valid(in_q2_valid), .in_q1(in_q1), .in_q2(in_q2),
    .in_imm(in_imm), .in_pc(in_pc), .in_rob_tag(in_rob_tag), .full(full),
    .alu_cdb_valid(alu_cdb_valid), .lsb_cdb_valid(lsb_cdb_valid),
    .alu_cdb_tag(alu_cdb_tag), .lsb_cdb_tag(lsb_cdb_tag),
    .alu_cdb_value(alu_cdb_value), .lsb_cdb_value(lsb_cdb_value),
    .out_openum(out_openum), .out_v1(out_v1), .out_v2(out_v2), .out_imm(out_imm),
    .out_pc(out_pc), .out_rob_tag(out_rob_tag)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] v1, v2;
    logic        q1v;
    logic [3:0]  q1;
    logic        q2v;
    logic [3:0]  q2;
    logic [31:0] imm, pc;
    logic [3:0]  tag;
    logic        acv;
    logic [3:0]  act;
    logic [31:0] acval;
    logic        lcv;
    logic [3:0]  lct;
    logic [31:0] lcval;
    logic [31:0] exp_v1, exp_v2;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; flush = 1'b0;
    alu_cdb_valid = 1'b0; lsb_cdb_valid = 1'b0;
  endtask

  // Advance one rising edge, then land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic set_op(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                        input logic q1v, input logic [3:0] q1, input logic q2v, input logic [3:0] q2,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
    in_valid = 1'b1; in_openum = op; in_v1 = v1; in_v2 = v2;
    in_q1_valid = q1v; in_q1 = q1; in_q2_valid = q2v; in_q2 = q2;
    in_imm = imm; in_pc = pc; in_rob_tag = tag;
  endtask

  task automatic set_cdb(input logic av, input logic [3:0] at, input logic [31:0] aval,
                         input logic lv, input logic [3:0] lt, input logic [31:0] lval);
    alu_cdb_valid = av; alu_cdb_tag = at; alu_cdb_value = aval;
    lsb_cdb_valid = lv; lsb_cdb_tag = lt; lsb_cdb_value = lval;
  endtask

  task automatic expect_nop(input string name);
    check({name, ".openum"}, 32'(out_openum), 32'(OPENUM_NOP));
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1;
    clear_inputs();
    set_op(6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    set_cdb(0, 0, 0, 0, 0, 0);

    vecs[0] = '{6'(OPENUM_ADDI), 32'd5, 32'd0, 0, 4'd0, 0, 4'd0, 32'd7, 32'h40, 4'd3,
                0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 32'd5, 32'd0};
    vecs[1] = '{6'(OPENUM_SUB), 32'hdead, 32'd3, 1, 4'd4, 0, 4'd0, 32'd0, 32'h44, 4'd6,
                1, 4'd4, 32'd9, 0, 4'd0, 32'd0, 32'd9, 32'd3};
    vecs[2] = '{6'(OPENUM_ADD), 32'd1, 32'hbeef, 0, 4'd0, 1, 4'd6, 32'd0, 32'h48, 4'd7,
                0, 4'd0, 32'd0, 1, 4'd6, 32'h20, 32'd1, 32'h20};
    vecs[3] = '{6'(OPENUM_AND), 32'd0, 32'd0, 1, 4'd7, 1, 4'd7, 32'd0, 32'h4c, 4'd8,
                1, 4'd7, 32'h11, 1, 4'd7, 32'h22, 32'h11, 32'h11};
    vecs[4] = '{6'(OPENUM_OR), 32'haa, 32'h1, 0, 4'd5, 0, 4'd0, 32'd0, 32'h50, 4'd9,
                1, 4'd5, 32'h55, 0, 4'd0, 32'd0, 32'haa, 32'h1};
    vecs[5] = '{6'(OPENUM_BEQ), 32'h42, 32'h42, 0, 4'd0, 0, 4'd0, 32'h20, 32'h100, 4'd15,
                0, 4'd0, 32'd0, 0, 4'd0, 32'd0, 32'h42, 32'h42};

    repeat (2) @(negedge clk);
    check("reset.openum", 32'(out_openum), 32'(OPENUM_NOP));
    check("reset.v1", out_v1, 32'd0);
    check("reset.rob_tag", 32'(out_rob_tag), 32'd0);
    check("reset.full", 32'(full), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single-op table: dispatch (optionally with CDB bypass), issue next edge, NOP after.
    for (int i = 0; i < 6; i++) begin
      set_op(vecs[i].op, vecs[i].v1, vecs[i].v2, vecs[i].q1v, vecs[i].q1, vecs[i].q2v,
             vecs[i].q2, vecs[i].imm, vecs[i].pc, vecs[i].tag);
      set_cdb(vecs[i].acv, vecs[i].act, vecs[i].acval, vecs[i].lcv, vecs[i].lct, vecs[i].lcval);
      tick();
      expect_nop($sformatf("vec%0d.e0", i));
      tick();
      check($sformatf("vec%0d.openum", i), 32'(out_openum), 32'(vecs[i].op));
      check($sformatf("vec%0d.v1", i), out_v1, vecs[i].exp_v1);
      check($sformatf("vec%0d.v2", i), out_v2, vecs[i].exp_v2);
      check($sformatf("vec%0d.imm", i), out_imm, vecs[i].imm);
      check($sformatf("vec%0d.pc", i), out_pc, vecs[i].pc);
      check($sformatf("vec%0d.rob_tag", i), 32'(out_rob_tag), 32'(vecs[i].tag));
      tick();
      expect_nop($sformatf("vec%0d.e2", i));
    end

    // Wakeup: both CDBs wake different operands of one entry in the same cycle.
    set_op(6'(OPENUM_ADD), 0, 0, 1, 4'd2, 1, 4'd5, 0, 32'h200, 4'd1);
    tick();
    tick();
    expect_nop("wake.pending");
    set_cdb(1, 4'd2, 32'h10, 1, 4'd5, 32'h20);
    tick();
    expect_nop("wake.edgeN");
    tick();
    check("wake.openum", 32'(out_openum), 32'(OPENUM_ADD));
    check("wake.v1", out_v1, 32'h10);
    check("wake.v2", out_v2, 32'h20);
    check("wake.rob_tag", 32'(out_rob_tag), 32'd1);
    tick();
    expect_nop("wake.after");

    // Full and priority: 16 blocked ops; entries 2 and 7 wait on unique tags.
    for (int i = 0; i < 16; i++) begin
      set_op(6'(OPENUM_XOR), 0, 32'(i), 1, (i == 2) ? 4'd2 : (i == 7) ? 4'd7 : 4'd0,
             0, 0, 0, 32'(i), 4'(i));
      tick();
      if (i == 14) check("fill.not_full_15", 32'(full), 32'd0);
    end
    check("fill.full_16", 32'(full), 32'd1);
    set_op(6'(OPENUM_ADDI), 32'h77, 0, 0, 0, 0, 0, 0, 0, 4'd9);
    tick();
    check("fill.drop_full", 32'(full), 32'd1);
    tick();
    expect_nop("fill.dropped_no_issue");
    set_cdb(1, 4'd2, 32'h2, 1, 4'd7, 32'h7);
    tick();
    expect_nop("prio.edgeN");
    check("prio.full_edgeN", 32'(full), 32'd1);
    tick();
    check("prio.first_tag", 32'(out_rob_tag), 32'd2);
    check("prio.first_v1", out_v1, 32'h2);
    check("prio.full_drops", 32'(full), 32'd0);
    tick();
    check("prio.second_tag", 32'(out_rob_tag), 32'd7);
    check("prio.second_v1", out_v1, 32'h7);
    tick();
    expect_nop("prio.after");

    // Flush the 14 remaining entries; a later tag-0 broadcast must not wake them.
    flush = 1'b1;
    tick();
    expect_nop("flush.openum");
    check("flush.full", 32'(full), 32'd0);
    set_cdb(1, 4'd0, 32'h5a, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_nop($sformatf("flush.no_issue%0d", i));
    end

    // Flush takes priority over an issue of a ready entry.
    set_op(6'(OPENUM_ORI), 32'h3, 0, 0, 0, 0, 0, 32'h1, 0, 4'd10);
    tick();
    flush = 1'b1;
    tick();
    expect_nop("flush.beats_issue");
    tick();
    expect_nop("flush.beats_issue_later");

    // rdy low: outputs and state frozen; flush and in_valid ignored.
    set_op(6'(OPENUM_ADDI), 32'h44, 0, 0, 0, 0, 0, 32'h4, 0, 4'd4);
    tick();
    set_op(6'(OPENUM_XORI), 32'h55, 0, 0, 0, 0, 0, 32'h5, 0, 4'd5);
    tick();
    check("rdy.x_tag", 32'(out_rob_tag), 32'd4);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      flush = 1'b1;
      set_op(6'(OPENUM_ANDI), 32'h66, 0, 0, 0, 0, 0, 0, 0, 4'd6);
      tick();
      check($sformatf("rdy.hold_tag%0d", i), 32'(out_rob_tag), 32'd4);
      check($sformatf("rdy.hold_v1_%0d", i), out_v1, 32'h44);
    end
    rdy = 1'b1;
    tick();
    check("rdy.resume_tag", 32'(out_rob_tag), 32'd5);
    check("rdy.resume_op", 32'(out_openum), 32'(OPENUM_XORI));
    tick();
    expect_nop("rdy.no_extra");

    // Asynchronous reset mid-operation with three entries held.
    set_op(6'(OPENUM_SUB), 0, 0, 1, 4'd3, 0, 0, 0, 0, 4'd11);
    tick();
    set_op(6'(OPENUM_SUB), 0, 0, 1, 4'd3, 0, 0, 0, 0, 4'd12);
    tick();
    set_op(6'(OPENUM_ADDI), 32'h9, 0, 0, 0, 0, 0, 0, 0, 4'd13);
    tick();
    tick();
    check("rst.pre_tag", 32'(out_rob_tag), 32'd13);
    #2 rst_n = 1'b0;
    #1;
    expect_nop("rst.async_openum");
    check("rst.async_tag", 32'(out_rob_tag), 32'd0);
    check("rst.async_full", 32'(full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_cdb(1, 4'd3, 32'h33, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_nop($sformatf("rst.no_issue%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
